// File: rtl/pipeline_pkg.sv
// Shared definitions for the elastic pipeline: slice state encoding and
// the occupancy counter width helper.
package pipeline_pkg;

  // Beats held by one slice: none, main register only, main plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } slice_state_e;

  // Counter width able to represent 0 .. 2*depth held beats.
  function automatic int occ_width(input int depth);
    return $clog2(2 * depth + 1);
  endfunction

endpackage

// File: rtl/pipeline_elastic_slice.sv
// One elastic register slice: a main register feeding the output and a skid
// register that catches the beat accepted in the cycle the output stalls.
// in_ready and out_valid decode only the registered state, so out_ready has
// no combinational path to in_ready.
module pipeline_elastic_slice
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output slice_state_e     state
);

  slice_state_e     state_q;
  slice_state_e     state_d;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             push;
  logic             pop;
  logic             load_main;
  logic             load_skid;
  logic             main_from_skid;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // State register; reset empties the slice immediately.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and datapath load enables from the push/pop handshakes.
  always_comb begin
    state_d        = state_q;
    load_main      = 1'b0;
    load_skid      = 1'b0;
    main_from_skid = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d   = ST_HALF;
          load_main = 1'b1;
        end
      end
      ST_HALF: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          state_d   = ST_FULL;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can happen.
        if (pop) begin
          state_d        = ST_HALF;
          main_from_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // Handshake outputs decoded from the registered state only.
  always_comb begin
    in_ready  = (state_q != ST_FULL);
    out_valid = (state_q != ST_EMPTY);
    out_data  = main_q;
    state     = state_q;
  end

  // Main and skid payload registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) begin
        main_q <= in_data;
      end else if (main_from_skid) begin
        main_q <= skid_q;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/pipeline_elastic.sv
// Elastic pipeline of DEPTH cascaded skid slices, capacity 2*DEPTH beats,
// latency DEPTH cycles, one beat per cycle when unstalled.
// Handshake: a beat moves across an interface on a rising edge where valid
// and ready are both high; valid never depends on ready, and once valid is
// high the payload holds until it is taken.
// Optional feature macro: PIPELINE_ELASTIC_OCCUPANCY_EN adds the occupancy
// port, a registered count of beats held.
// slice_state exposes each slice's state, two bits per slice, slice 0 lowest.
module pipeline_elastic
  import pipeline_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [WIDTH-1:0]                  in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [WIDTH-1:0]                  out_data,
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
  output logic [$clog2(2*DEPTH+1)-1:0]      occupancy,
`endif
  output logic [2*DEPTH-1:0]                slice_state
);

  logic [DEPTH:0]   v;
  logic [DEPTH:0]   r;
  logic [WIDTH-1:0] d [0:DEPTH];

  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign in_ready  = r[0];
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign r[DEPTH]  = out_ready;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    slice_state_e st;

    pipeline_elastic_slice #(
      .WIDTH(WIDTH)
    ) u_slice (
      .clk      (clk),
      .resetn   (resetn),
      .in_valid (v[k]),
      .in_ready (r[k]),
      .in_data  (d[k]),
      .out_valid(v[k+1]),
      .out_ready(r[k+1]),
      .out_data (d[k+1]),
      .state    (st)
    );

    assign slice_state[2*k +: 2] = st;
  end

`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
  localparam int CW = occ_width(DEPTH);

  logic          occ_push;
  logic          occ_pop;
  logic [CW-1:0] occ_q;

  assign occ_push  = in_valid && in_ready;
  assign occ_pop   = out_valid && out_ready;
  assign occupancy = occ_q;

  // Beats held: up on accept only, down on delivery only.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      occ_q <= '0;
    end else if (occ_push && !occ_pop) begin
      occ_q <= occ_q + 1'b1;
    end else if (occ_pop && !occ_push) begin
      occ_q <= occ_q - 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_elastic.sv
// Self-checking bench for pipeline_elastic (WIDTH=8, DEPTH=3). A FIFO queue
// of accepted beats is the reference; occupancy is checked when the
// PIPELINE_ELASTIC_OCCUPANCY_EN build is used.
module tb_pipeline_elastic;

  localparam int WIDTH = 8;
  localparam int DEPTH = 3;
  localparam int CAP   = 2 * DEPTH;
  localparam int CW    = $clog2(2 * DEPTH + 1);

  logic             clk;
  logic             resetn;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    occupancy;
  logic [2*DEPTH-1:0] slice_state;

  int checks;
  int failures;
  int acc_cnt;
  int pop_cnt;

  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] fill_q[$];
  logic             stall_prev;
  logic [WIDTH-1:0] stall_data;

  pipeline_elastic #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    .occupancy  (occupancy),
`endif
    .slice_state(slice_state)
  );

`ifndef PIPELINE_ELASTIC_OCCUPANCY_EN
  assign occupancy = '0;
`endif

  // Clock and time limit
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  // One cycle: scoreboard the handshakes that the next edge commits, then
  // advance to just after that edge. Callers drive inputs before calling.
  task automatic step();
    #2;
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++;
    if (occupancy !== CW'(exp_q.size())) begin
      failures++;
      $display("FAIL occupancy: got %0d expected %0d", occupancy, exp_q.size());
    end
`endif
    if (stall_prev) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== stall_data) begin
        failures++;
        $display("FAIL stall_stable: got valid=%b data=%h expected valid=1 data=%h",
                 out_valid, out_data, stall_data);
      end
    end
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      pop_cnt++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat: got data=%h expected no beat", out_data);
      end else begin
        logic [WIDTH-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL out_order: got %h expected %h", out_data, e);
        end
      end
    end
    if (in_valid === 1'b1 && in_ready === 1'b1) begin
      exp_q.push_back(in_data);
      acc_cnt++;
    end
    checks++;
    if (exp_q.size() > CAP) begin
      failures++;
      $display("FAIL capacity: got %0d held expected at most %0d", exp_q.size(), CAP);
    end
    stall_prev = (out_valid === 1'b1) && (out_ready !== 1'b1);
    stall_data = out_data;
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 100) begin
      step();
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_drain: got %0d beats left valid=%b expected 0 left valid=0",
               name, exp_q.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    resetn    = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #1;
    resetn = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got valid=%b data=%h ready=%b expected 0 00 1",
               out_valid, out_data, in_ready);
    end
    checks++;
    if (slice_state !== '0) begin
      failures++;
      $display("FAIL reset_state: got %b expected all empty", slice_state);
    end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL reset_occupancy: got %0d expected 0", occupancy);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_q.delete();
    stall_prev = 1'b0;
  endtask

  task automatic test_latency();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    step();
    in_valid = 1'b0;
    for (int e = 0; e < DEPTH + 1; e++) begin
      logic exp_v;
      exp_v = (e == DEPTH - 1);
      checks++;
      if (out_valid !== exp_v || (exp_v && out_data !== 8'h11)) begin
        failures++;
        $display("FAIL latency_edge%0d: got valid=%b data=%h expected valid=%b data=11",
                 e, out_valid, out_data, exp_v);
      end
      if (e < DEPTH) step();
    end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL latency_occupancy: got %0d expected 0", occupancy);
    end
`endif
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    fill_q.delete();
    for (int c = 0; c < 40; c++) begin
      in_data = 8'($urandom);
      if (in_ready === 1'b1) fill_q.push_back(in_data);
      step();
    end
    checks++;
    if (fill_q.size() != CAP || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_count: got %0d accepted ready=%b expected %0d ready=0",
               fill_q.size(), in_ready, CAP);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== fill_q[0]) begin
      failures++;
      $display("FAIL fill_head: got valid=%b data=%h expected valid=1 data=%h",
               out_valid, out_data, fill_q[0]);
    end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++;
    if (occupancy !== CW'(CAP)) begin
      failures++;
      $display("FAIL fill_occupancy: got %0d expected %0d", occupancy, CAP);
    end
`endif
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < CAP; i++) begin
      logic exp_r;
      exp_r = (i >= DEPTH);
      checks++;
      if (out_valid !== 1'b1 || out_data !== fill_q[i]) begin
        failures++;
        $display("FAIL drain_beat%0d: got valid=%b data=%h expected valid=1 data=%h",
                 i, out_valid, out_data, fill_q[i]);
      end
      checks++;
      if (in_ready !== exp_r) begin
        failures++;
        $display("FAIL drain_ready%0d: got %b expected %b", i, in_ready, exp_r);
      end
      in_data = 8'($urandom);
      step();
    end
    drain("full");
  endtask

  task automatic test_random();
    logic ro;
    logic r0;
    int   vp;
    int   rp;
    acc_cnt = 0;
    pop_cnt = 0;
    for (int c = 0; c < 10000; c++) begin
      if (c % 1000 == 0) begin
        vp = $urandom_range(10, 100);
        rp = $urandom_range(10, 100);
      end
      in_valid = ($urandom_range(0, 99) < vp);
      in_data  = 8'($urandom);
      ro       = ($urandom_range(0, 99) < rp);
      out_ready = !ro;
      #1;
      r0 = in_ready;
      out_ready = ro;
      #1;
      checks++;
      if (in_ready !== r0) begin
        failures++;
        $display("FAIL ready_path: in_ready moved with out_ready, got %b expected %b", in_ready, r0);
      end
      step();
    end
    drain("random");
    checks++;
    if (acc_cnt != pop_cnt) begin
      failures++;
      $display("FAIL random_count: got %0d out expected %0d", pop_cnt, acc_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] fresh;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'($urandom);
      step();
    end
    in_valid = 1'b0;
    step();
    #2;
    resetn   = 1'b0;
    in_valid = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0) begin
      failures++;
      $display("FAIL midreset_outputs: got valid=%b ready=%b data=%h expected 0 1 00",
               out_valid, in_ready, out_data);
    end
`ifdef PIPELINE_ELASTIC_OCCUPANCY_EN
    checks++;
    if (occupancy !== '0) begin
      failures++;
      $display("FAIL midreset_occupancy: got %0d expected 0", occupancy);
    end
`endif
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0 || slice_state !== '0) begin
      failures++;
      $display("FAIL midreset_no_transfer: got valid=%b state=%b expected 0 and empty",
               out_valid, slice_state);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    resetn    = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL stale_beat: got valid=1 data=%h expected valid=0", out_data);
      end
      step();
    end
    fresh    = 8'hA5;
    in_data  = fresh;
    in_valid = 1'b1;
    step();
    drain("postreset");
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    acc_cnt    = 0;
    pop_cnt    = 0;
    stall_prev = 1'b0;
    stall_data = '0;
    test_reset();
    test_latency();
    test_fill();
    test_drain();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
